// File: rtl/moore_state_monitor_if.sv
// Bundle of the sampling controls and observation outputs of moore_state_monitor.
// The bench drives through master; the monitor attaches through slave.
interface moore_state_monitor_if #(
  parameter int CW = 4,
  parameter int DW = 8
);
  logic          clear;
  logic          enable;
  logic [1:0]    state_in;
  logic          change;
  logic          seq_hit;
  logic          illegal;
  logic          illegal_seen;
  logic [3:0]    illegal_info;
  logic [DW-1:0] dwell;
  logic [CW-1:0] visits_s0;
  logic [CW-1:0] visits_s1;
  logic [CW-1:0] visits_s2;
  logic [CW-1:0] visits_s3;

  modport master (
    output clear, enable, state_in,
    input  change, seq_hit, illegal, illegal_seen, illegal_info, dwell,
    input  visits_s0, visits_s1, visits_s2, visits_s3
  );

  modport slave (
    input  clear, enable, state_in,
    output change, seq_hit, illegal, illegal_seen, illegal_info, dwell,
    output visits_s0, visits_s1, visits_s2, visits_s3
  );
endinterface

// File: rtl/moore_state_monitor.sv
// Passive observer of a 2-bit Moore FSM state: change/illegal-step detection,
// per-state entry counts, dwell time and 3-entry sequence match.
module moore_state_monitor #(
  parameter int         CW  = 4,
  parameter int         DW  = 8,
  parameter logic [5:0] SEQ = 6'b00_10_11
) (
  input logic                  clock,
  input logic                  reset,
  moore_state_monitor_if.slave mon
);

  logic [1:0]    prev_q, prev_d;
  logic          prev_valid_q, prev_valid_d;
  logic [3:0]    hist_q, hist_d;
  logic [1:0]    hist_cnt_q, hist_cnt_d;
  logic          change_q, change_d;
  logic          seq_hit_q, seq_hit_d;
  logic          illegal_q, illegal_d;
  logic          illegal_seen_q, illegal_seen_d;
  logic [3:0]    illegal_info_q, illegal_info_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] visits_q [4];
  logic [CW-1:0] visits_d [4];
  logic [1:0]    cur_s;
  logic [5:0]    hist_shift_s;

  function automatic logic legal_step(input logic [1:0] p, input logic [1:0] c);
    logic ok;
    case (p)
      2'd0:    ok = (c == 2'd2) || (c == 2'd3);
      2'd1:    ok = (c == 2'd1) || (c == 2'd3);
      2'd2:    ok = (c == 2'd2) || (c == 2'd3);
      2'd3:    ok = (c == 2'd0) || (c == 2'd2);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [CW-1:0] visit_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Next-state: clear, enable gap, first sample after a gap, or continued sampling.
  always_comb begin
    cur_s          = mon.state_in;
    hist_shift_s   = {hist_q, cur_s};
    prev_d         = prev_q;
    prev_valid_d   = prev_valid_q;
    hist_d         = hist_q;
    hist_cnt_d     = hist_cnt_q;
    change_d       = 1'b0;
    seq_hit_d      = 1'b0;
    illegal_d      = 1'b0;
    illegal_seen_d = illegal_seen_q;
    illegal_info_d = illegal_info_q;
    dwell_d        = dwell_q;
    visits_d       = visits_q;
    if (mon.clear) begin
      prev_d         = 2'd0;
      prev_valid_d   = 1'b0;
      hist_d         = 4'd0;
      hist_cnt_d     = 2'd0;
      illegal_seen_d = 1'b0;
      illegal_info_d = 4'd0;
      dwell_d        = {DW{1'b0}};
      visits_d       = '{default: {CW{1'b0}}};
    end else if (!mon.enable) begin
      prev_valid_d = 1'b0;
      hist_cnt_d   = 2'd0;
    end else if (!prev_valid_q) begin
      prev_d          = cur_s;
      prev_valid_d    = 1'b1;
      visits_d[cur_s] = visit_inc(visits_q[cur_s]);
      dwell_d         = DW'(1);
      hist_d          = hist_shift_s[3:0];
      hist_cnt_d      = 2'd1;
    end else begin
      prev_d = cur_s;
      if (!legal_step(prev_q, cur_s)) begin
        illegal_d      = 1'b1;
        illegal_seen_d = 1'b1;
        if (!illegal_seen_q) begin
          illegal_info_d = {prev_q, cur_s};
        end else begin
          illegal_info_d = illegal_info_q;
        end
      end else begin
        illegal_d = 1'b0;
      end
      // Only a genuine entry advances history, so self-loops can never complete SEQ.
      if (cur_s != prev_q) begin
        change_d        = 1'b1;
        visits_d[cur_s] = visit_inc(visits_q[cur_s]);
        dwell_d         = DW'(1);
        hist_d          = hist_shift_s[3:0];
        hist_cnt_d      = (hist_cnt_q == 2'd3) ? 2'd3 : hist_cnt_q + 2'd1;
        seq_hit_d       = (hist_cnt_d == 2'd3) && (hist_shift_s == SEQ);
      end else if (dwell_q != {DW{1'b1}}) begin
        dwell_d = dwell_q + DW'(1);
      end else begin
        dwell_d = dwell_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q         <= 2'd0;
      prev_valid_q   <= 1'b0;
      hist_q         <= 4'd0;
      hist_cnt_q     <= 2'd0;
      change_q       <= 1'b0;
      seq_hit_q      <= 1'b0;
      illegal_q      <= 1'b0;
      illegal_seen_q <= 1'b0;
      illegal_info_q <= 4'd0;
      dwell_q        <= {DW{1'b0}};
      visits_q       <= '{default: {CW{1'b0}}};
    end else begin
      prev_q         <= prev_d;
      prev_valid_q   <= prev_valid_d;
      hist_q         <= hist_d;
      hist_cnt_q     <= hist_cnt_d;
      change_q       <= change_d;
      seq_hit_q      <= seq_hit_d;
      illegal_q      <= illegal_d;
      illegal_seen_q <= illegal_seen_d;
      illegal_info_q <= illegal_info_d;
      dwell_q        <= dwell_d;
      visits_q       <= visits_d;
    end
  end

  assign mon.change       = change_q;
  assign mon.seq_hit      = seq_hit_q;
  assign mon.illegal      = illegal_q;
  assign mon.illegal_seen = illegal_seen_q;
  assign mon.illegal_info = illegal_info_q;
  assign mon.dwell        = dwell_q;
  assign mon.visits_s0    = visits_q[0];
  assign mon.visits_s1    = visits_q[1];
  assign mon.visits_s2    = visits_q[2];
  assign mon.visits_s3    = visits_q[3];

endmodule

// File: tb/tb_moore_state_monitor.sv
// Directed + random scoreboard bench for moore_state_monitor; a second instance
// with narrow counters exercises saturation.
module tb_moore_state_monitor;

  logic clock = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clock = ~clock;

  moore_state_monitor_if #(.CW(4), .DW(8)) m1 ();
  moore_state_monitor_if #(.CW(2), .DW(2)) m2 ();

  moore_state_monitor #(.CW(4), .DW(8), .SEQ(6'b00_10_11)) dut1 (
    .clock(clock), .reset(reset), .mon(m1)
  );
  moore_state_monitor #(.CW(2), .DW(2), .SEQ(6'b00_10_11)) dut2 (
    .clock(clock), .reset(reset), .mon(m2)
  );

  typedef struct packed {
    logic       change;
    logic       seq_hit;
    logic       illegal;
    logic       illegal_seen;
    logic [3:0] info;
    logic [7:0] dwell;
    logic [3:0] v0, v1, v2, v3;
  } exp_t;

  typedef struct packed {
    logic [1:0] dwell;
    logic [1:0] v0;
    logic [1:0] v3;
  } exp2_t;

  exp_t       sb_q[$];
  exp2_t      sb2_q[$];
  exp_t       m;
  logic [1:0] mp;
  logic       mpv;
  logic [3:0] mh;
  int         mhc;
  logic [15:0] legal_tab = 16'h5CAC;  // bit {prev,cur} set when the step is legal

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m   = '0;
    mp  = 2'd0;
    mpv = 1'b0;
    mh  = 4'd0;
    mhc = 0;
  endtask

  task automatic model_enter(input logic [1:0] st);
    case (st)
      2'd0: if (m.v0 != 4'hF) m.v0 = m.v0 + 4'd1;
      2'd1: if (m.v1 != 4'hF) m.v1 = m.v1 + 4'd1;
      2'd2: if (m.v2 != 4'hF) m.v2 = m.v2 + 4'd1;
      default: if (m.v3 != 4'hF) m.v3 = m.v3 + 4'd1;
    endcase
    m.dwell = 8'd1;
    m.seq_hit = (mhc >= 2) && ({mh, st} == 6'b00_10_11);
    mh = {mh[1:0], st};
    mhc = (mhc < 3) ? mhc + 1 : 3;
  endtask

  task automatic model_step(input logic clr, input logic en, input logic [1:0] st);
    m.change  = 1'b0;
    m.seq_hit = 1'b0;
    m.illegal = 1'b0;
    if (clr) begin
      model_reset();
    end else if (!en) begin
      mpv = 1'b0;
      mhc = 0;
    end else begin
      if (mpv) begin
        if (!legal_tab[{mp, st}]) begin
          m.illegal = 1'b1;
          if (!m.illegal_seen) m.info = {mp, st};
          m.illegal_seen = 1'b1;
        end
        if (st == mp) begin
          if (m.dwell != 8'hFF) m.dwell = m.dwell + 8'd1;
        end else begin
          m.change = 1'b1;
          model_enter(st);
        end
      end else begin
        model_enter(st);
        mpv = 1'b1;
      end
      mp = st;
    end
  endtask

  task automatic step(input logic clr, input logic en, input logic [1:0] st);
    exp_t e;
    m1.clear    = clr;
    m1.enable   = en;
    m1.state_in = st;
    model_step(clr, en, st);
    sb_q.push_back(m);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    chk("change",       {31'd0, m1.change},       {31'd0, e.change});
    chk("seq_hit",      {31'd0, m1.seq_hit},      {31'd0, e.seq_hit});
    chk("illegal",      {31'd0, m1.illegal},      {31'd0, e.illegal});
    chk("illegal_seen", {31'd0, m1.illegal_seen}, {31'd0, e.illegal_seen});
    chk("illegal_info", {28'd0, m1.illegal_info}, {28'd0, e.info});
    chk("dwell",        {24'd0, m1.dwell},        {24'd0, e.dwell});
    chk("visits_s0",    {28'd0, m1.visits_s0},    {28'd0, e.v0});
    chk("visits_s1",    {28'd0, m1.visits_s1},    {28'd0, e.v1});
    chk("visits_s2",    {28'd0, m1.visits_s2},    {28'd0, e.v2});
    chk("visits_s3",    {28'd0, m1.visits_s3},    {28'd0, e.v3});
  endtask

  task automatic run_seq(input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2);
    step(1'b0, 1'b1, s0);
    step(1'b0, 1'b1, s1);
    step(1'b0, 1'b1, s2);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_change"},  {31'd0, m1.change},       32'd0);
    chk({tag, "_seq_hit"}, {31'd0, m1.seq_hit},      32'd0);
    chk({tag, "_illegal"}, {31'd0, m1.illegal},      32'd0);
    chk({tag, "_seen"},    {31'd0, m1.illegal_seen}, 32'd0);
    chk({tag, "_info"},    {28'd0, m1.illegal_info}, 32'd0);
    chk({tag, "_dwell"},   {24'd0, m1.dwell},        32'd0);
    chk({tag, "_visits"},  {16'd0, m1.visits_s0, m1.visits_s1, m1.visits_s2, m1.visits_s3}, 32'd0);
    chk({tag, "_n_dwell"}, {30'd0, m2.dwell},        32'd0);
  endtask

  task automatic step2(input logic [1:0] st, input exp2_t ex);
    exp2_t e;
    m2.enable   = 1'b1;
    m2.state_in = st;
    sb2_q.push_back(ex);
    @(posedge clock);
    #1;
    e = sb2_q.pop_front();
    chk("n_dwell",     {30'd0, m2.dwell},     {30'd0, e.dwell});
    chk("n_visits_s0", {30'd0, m2.visits_s0}, {30'd0, e.v0});
    chk("n_visits_s3", {30'd0, m2.visits_s3}, {30'd0, e.v3});
  endtask

  initial begin
    reset = 1'b0;
    m1.clear = 1'b0; m1.enable = 1'b0; m1.state_in = 2'd0;
    m2.clear = 1'b0; m2.enable = 1'b0; m2.state_in = 2'd0;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Legal walk 0,3,2,3,0
    step(1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b1, 2'd3);
    step(1'b0, 1'b1, 2'd2);
    step(1'b0, 1'b1, 2'd3);
    step(1'b0, 1'b1, 2'd0);
    chk("t1_v0", {28'd0, m1.visits_s0}, 32'd2);
    chk("t1_v3", {28'd0, m1.visits_s3}, 32'd2);
    chk("t1_v2", {28'd0, m1.visits_s2}, 32'd1);

    // Sequence 0,2,3 completes twice; self-loop on 2 must not fire early
    step(1'b0, 1'b1, 2'd2);
    step(1'b0, 1'b1, 2'd3);
    chk("t2_hit1", {31'd0, m1.seq_hit}, 32'd1);
    run_seq(2'd0, 2'd2, 2'd3);
    chk("t2_hit2", {31'd0, m1.seq_hit}, 32'd1);
    step(1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b1, 2'd2);
    step(1'b0, 1'b1, 2'd2);
    step(1'b0, 1'b1, 2'd3);

    // Illegal steps 0->1 and 3->3; info latches the first one only
    run_seq(2'd0, 2'd1, 2'd3);
    step(1'b0, 1'b1, 2'd3);
    chk("t3_info", {28'd0, m1.illegal_info}, 32'h1);

    // Dwell in S2
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd2);
    chk("t4_dwell", {24'd0, m1.dwell}, 32'd4);

    // Enable gap between 0 and 1 breaks continuity; then clear beats enable
    step(1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd1);
    chk("t6_gap", {31'd0, m1.illegal}, 32'd0);
    step(1'b1, 1'b1, 2'd2);
    run_seq(2'd0, 2'd1, 2'd1);

    // Random traffic with occasional gaps and clears
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)));
    end

    // Asynchronous reset mid-run
    run_seq(2'd0, 2'd2, 2'd3);
    m1.enable = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    run_seq(2'd2, 2'd0, 2'd3);

    // Narrow instance: dwell and visit saturation
    m1.enable = 1'b0;
    for (int i = 0; i < 6; i++) step2(2'd2, '{dwell: 2'((i < 3) ? i + 1 : 3), v0: 2'd0, v3: 2'd0});
    for (int i = 0; i < 5; i++) begin
      step2(2'd0, '{dwell: 2'd1, v0: 2'((i < 3) ? i + 1 : 3), v3: 2'((i < 3) ? i : 3)});
      step2(2'd3, '{dwell: 2'd1, v0: 2'((i < 3) ? i + 1 : 3), v3: 2'((i < 3) ? i + 1 : 3)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
